// File: rtl/vec_mem_stage.sv
// Vector memory stage: serialises per-lane loads/stores onto a single-port data memory.
// Optional per-lane enable mask when VEC_MEM_LANE_MASK_EN is defined.
module vec_mem_stage #(
  parameter int unsigned LANES = 16,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                v_s,
`ifdef VEC_MEM_LANE_MASK_EN
  input  logic [LANES-1:0]    lane_mask,
`endif
  input  logic [LANES*DW-1:0] addr,
  input  logic [LANES*DW-1:0] wdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DW-1:0]       mem_rdata,
  output logic [LANES*DW-1:0] read_data,
  output logic                out_valid,
  output logic                busy
);

  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                     state;
  logic [LW-1:0]              lane;
  logic                       store_q;
  logic [LANES-1:0]           mask_q;
  logic [LANES-1:0][DW-1:0]   addr_q;
  logic [LANES-1:0][DW-1:0]   wdata_q;
  logic [LANES-1:0][DW-1:0]   rdata_q;

  logic [LANES-1:0]           mask_in;
  logic [LANES-1:0]           eff_mask;
  logic                       first_found;
  logic [LW-1:0]              first_lane;
  logic                       next_found;
  logic [LW-1:0]              next_lane;

  // Scalar ops only ever touch lane 0, so the active set collapses to bit 0.
  always_comb begin
`ifdef VEC_MEM_LANE_MASK_EN
    mask_in = lane_mask;
`else
    mask_in = '1;
`endif
    eff_mask = v_s ? mask_in : (mask_in & LANES'(1));

    first_found = 1'b0;
    first_lane  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!first_found && eff_mask[i]) begin
        first_found = 1'b1;
        first_lane  = LW'(i);
      end
    end

    next_found = 1'b0;
    next_lane  = lane;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!next_found && mask_q[i] && (i > 32'(lane))) begin
        next_found = 1'b1;
        next_lane  = LW'(i);
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign mem_req   = (state == REQ);
  assign mem_we    = (state == REQ) && store_q;
  assign mem_addr  = (state == REQ) ? AW'(addr_q[lane]) : '0;
  assign mem_wdata = ((state == REQ) && store_q) ? wdata_q[lane] : '0;
  assign read_data = rdata_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      lane      <= '0;
      store_q   <= 1'b0;
      mask_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            store_q <= mem_write;
            mask_q  <= eff_mask;
            rdata_q <= '0;
            lane    <= first_lane;
            // An empty active set behaves like a non-memory op.
            if (!(mem_read || mem_write) || !first_found) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            if (!store_q) begin
              state <= WAIT;
            end else if (next_found) begin
              lane <= next_lane;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            rdata_q[lane] <= mem_rdata;
            if (next_found) begin
              lane  <= next_lane;
              state <= REQ;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mem_stage.sv
// Self-checking bench for vec_mem_stage: memory responder with random grant/rvalid
// delays plus a lane-list reference model of the expected transactions and results.
module tb_vec_mem_stage;

  localparam int unsigned LANES = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned VW    = LANES * DW;

  logic             CLK;
  logic             RST_N;
  logic             in_valid;
  logic             in_ready;
  logic             mem_read;
  logic             mem_write;
  logic             v_s;
  logic [LANES-1:0] lane_mask;
  logic [VW-1:0]    addr;
  logic [VW-1:0]    wdata;
  logic             mem_req;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_gnt;
  logic             mem_rvalid;
  logic [DW-1:0]    mem_rdata;
  logic [VW-1:0]    read_data;
  logic             out_valid;
  logic             busy;

  vec_mem_stage #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .v_s        (v_s),
`ifdef VEC_MEM_LANE_MASK_EN
    .lane_mask  (lane_mask),
`endif
    .addr       (addr),
    .wdata      (wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .read_data  (read_data),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responder configuration and observation log
  int unsigned   gmin = 0, gmax = 0, rmin = 0, rmax = 0;
  int            lat_acc = 0;
  bit            stray = 1'b0;
  logic          t_we[$];
  logic [AW-1:0] t_addr[$];
  logic [DW-1:0] t_wd[$];
  logic [DW-1:0] rdq[$];

  initial begin
    bit            in_req, r_pend;
    int unsigned   req_cnt, g_del, r_cnt, r_del;
    logic [AW-1:0] h_addr;
    logic          h_we;
    logic [DW-1:0] h_wd;
    in_req = 1'b0; r_pend = 1'b0; req_cnt = 0; g_del = 0; r_cnt = 0; r_del = 0;
    h_addr = '0; h_we = 1'b0; h_wd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge CLK);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (!RST_N) begin
        in_req = 1'b0; r_pend = 1'b0; req_cnt = 0;
      end else begin
        if (stray) begin
          mem_rvalid = 1'b1;
          mem_rdata  = $urandom;
        end else if (r_pend) begin
          if (r_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = (rdq.size() > 0) ? rdq.pop_front() : 32'h0BAD_F00D;
            lat_acc   += int'(r_del) + 1;
            r_pend     = 1'b0;
          end else begin
            r_cnt--;
          end
        end
        if (mem_req) begin
          if (!in_req) begin
            in_req  = 1'b1;
            h_addr  = mem_addr;
            h_we    = mem_we;
            h_wd    = mem_wdata;
            g_del   = $urandom_range(gmax, gmin);
            req_cnt = 0;
          end else begin
            check_val("hold_addr", VW'(mem_addr), VW'(h_addr));
            check_val("hold_we", VW'(mem_we), VW'(h_we));
            check_val("hold_wdata", VW'(mem_wdata), VW'(h_wd));
          end
          if (req_cnt == g_del) begin
            mem_gnt = 1'b1;
            t_we.push_back(mem_we);
            t_addr.push_back(mem_addr);
            t_wd.push_back(mem_wdata);
            lat_acc += int'(g_del) + 1;
            in_req   = 1'b0;
            if (!mem_we) begin
              r_pend = 1'b1;
              r_del  = $urandom_range(rmax, rmin);
              r_cnt  = r_del;
            end
          end else begin
            req_cnt++;
          end
        end
      end
    end
  end

  function automatic logic [VW-1:0] rvec();
    logic [VW-1:0] v;
    for (int i = 0; i < int'(LANES); i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic run_op(input logic rd_i, input logic wr_i, input logic vs_i,
                        input logic [LANES-1:0] mask_i, input logic [VW-1:0] a_i,
                        input logic [VW-1:0] w_i, input logic [VW-1:0] rv_i,
                        input bit hold_i, output int lat_o);
    logic [LANES-1:0] act;
    logic [VW-1:0]    exp_rd;
    int               n, k;
    bit               seen;
`ifdef VEC_MEM_LANE_MASK_EN
    act = vs_i ? mask_i : (mask_i & LANES'(1));
`else
    act = vs_i ? '1 : LANES'(1);
`endif
    if (!(rd_i || wr_i)) act = '0;
    t_we.delete(); t_addr.delete(); t_wd.delete(); rdq.delete();
    lat_acc = 0;
    exp_rd  = '0;
    if (rd_i && !wr_i) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (act[i]) begin
          rdq.push_back(rv_i[i*DW +: DW]);
          exp_rd[i*DW +: DW] = rv_i[i*DW +: DW];
        end
      end
    end

    @(negedge CLK);
    check_val("in_ready", VW'(in_ready), VW'(1'b1));
    in_valid = 1'b1; mem_read = rd_i; mem_write = wr_i; v_s = vs_i;
    lane_mask = mask_i; addr = a_i; wdata = w_i;

    @(negedge CLK);
    n = 1; seen = 1'b0;
    while (n <= 600) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      check_val("busy", VW'(busy), VW'(1'b1));
      if (hold_i) begin
        mem_read  = 1'($urandom & 1);
        mem_write = 1'($urandom & 1);
        v_s       = 1'($urandom & 1);
        lane_mask = LANES'($urandom);
        addr      = rvec();
        wdata     = rvec();
      end else begin
        in_valid = 1'b0;
      end
      @(negedge CLK);
      n++;
    end
    in_valid = 1'b0;
    lat_o = n;
    check_val("done_seen", VW'(seen), VW'(1'b1));
    if (seen) begin
      check_val("latency", VW'(n), VW'(lat_acc + 1));
      check_val("busy_done", VW'(busy), VW'(1'b1));
      @(negedge CLK);
      check_val("pulse_once", VW'(out_valid), VW'(1'b0));
      check_val("idle_ready", VW'(in_ready), VW'(1'b1));
      check_val("idle_busy", VW'(busy), VW'(1'b0));
      check_val("txn_count", VW'(t_we.size()), VW'($countones(act)));
      k = 0;
      for (int i = 0; i < int'(LANES); i++) begin
        if (act[i]) begin
          if (k < t_we.size()) begin
            check_val("txn_we", VW'(t_we[k]), VW'(wr_i));
            check_val("txn_addr", VW'(t_addr[k]), VW'(a_i[i*DW +: DW]));
            if (wr_i) check_val("txn_wdata", VW'(t_wd[k]), VW'(w_i[i*DW +: DW]));
          end
          k++;
        end
      end
      check_val("read_data", read_data, exp_rd);
    end else begin
      do_reset();
    end
  endtask

  initial begin
    logic [VW-1:0] a, w, rv;
    int            lat, n;
    RST_N = 1'b0; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; v_s = 1'b0;
    lane_mask = '0; addr = '0; wdata = '0;
    #12;
    check_val("rst_req", VW'(mem_req), VW'(1'b0));
    check_val("rst_busy", VW'(busy), VW'(1'b0));
    check_val("rst_valid", VW'(out_valid), VW'(1'b0));
    check_val("rst_ready", VW'(in_ready), VW'(1'b1));
    check_val("rst_rdata", read_data, '0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Vector load, immediate grant, rvalid one cycle later
    for (int i = 0; i < int'(LANES); i++) begin
      a[i*DW +: DW]  = 32'h100 + 32'(4 * i);
      rv[i*DW +: DW] = 32'hA000_0000 + 32'(i);
    end
    gmin = 0; gmax = 0; rmin = 0; rmax = 0;
    run_op(1'b1, 1'b0, 1'b1, '1, a, rvec(), rv, 1'b0, lat);
    check_val("vload_lat", VW'(lat), VW'(33));

    // Vector store with two-cycle grant delay
    for (int i = 0; i < int'(LANES); i++) w[i*DW +: DW] = 32'(i * 3);
    gmin = 2; gmax = 2;
    run_op(1'b0, 1'b1, 1'b1, '1, a, w, rvec(), 1'b0, lat);
    check_val("vstore_lat", VW'(lat), VW'(49));

    // Scalar load and store
    gmin = 0; gmax = 0;
    a = rvec(); a[DW-1:0] = 32'h40;
    rv = rvec(); rv[DW-1:0] = 32'hDEAD_BEEF;
    run_op(1'b1, 1'b0, 1'b0, '1, a, rvec(), rv, 1'b0, lat);
    check_val("sload_lat", VW'(lat), VW'(3));
    run_op(1'b0, 1'b1, 1'b0, '1, rvec(), rvec(), rvec(), 1'b0, lat);
    check_val("sstore_lat", VW'(lat), VW'(2));

    // Non-memory op, then load+store together (store wins)
    run_op(1'b0, 1'b0, 1'b1, '1, rvec(), rvec(), rvec(), 1'b1, lat);
    check_val("nop_lat", VW'(lat), VW'(1));
    run_op(1'b1, 1'b1, 1'b1, '1, rvec(), rvec(), rvec(), 1'b0, lat);
    check_val("ldst_lat", VW'(lat), VW'(17));

`ifdef VEC_MEM_LANE_MASK_EN
    run_op(1'b1, 1'b0, 1'b1, 16'h0005, rvec(), rvec(), rvec(), 1'b0, lat);
    check_val("mask_lat", VW'(lat), VW'(5));
    run_op(1'b1, 1'b0, 1'b1, 16'h0000, rvec(), rvec(), rvec(), 1'b0, lat);
    check_val("mask0_lat", VW'(lat), VW'(1));
`endif

    // Reset during lane 5 of a vector load, then a stray rvalid
    t_we.delete(); t_addr.delete(); t_wd.delete(); rdq.delete();
    for (int i = 0; i < int'(LANES); i++) rdq.push_back($urandom);
    @(negedge CLK);
    in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; v_s = 1'b1;
    lane_mask = '1; addr = rvec(); wdata = rvec();
    @(negedge CLK);
    in_valid = 1'b0;
    n = 0;
    while (t_we.size() < 6 && n < 200) begin
      @(negedge CLK); #1;
      n++;
    end
    check_val("reach_lane5", VW'(t_we.size() >= 6), VW'(1'b1));
    #1 RST_N = 1'b0;
    #1;
    check_val("mid_rst_req", VW'(mem_req), VW'(1'b0));
    check_val("mid_rst_busy", VW'(busy), VW'(1'b0));
    check_val("mid_rst_rdata", read_data, '0);
    @(negedge CLK); #1;
    RST_N = 1'b1;
    stray = 1'b1;
    @(negedge CLK); #1;
    stray = 1'b0;
    repeat (3) begin
      @(negedge CLK); #1;
      check_val("post_rst_valid", VW'(out_valid), VW'(1'b0));
      check_val("post_rst_busy", VW'(busy), VW'(1'b0));
      check_val("post_rst_rdata", read_data, '0);
    end
    run_op(1'b1, 1'b0, 1'b1, '1, rvec(), rvec(), rvec(), 1'b0, lat);

    // Randomised ops with random grant/rvalid delays
    for (int t = 0; t < 40; t++) begin
      gmin = 0; gmax = $urandom_range(3, 0);
      rmin = 0; rmax = $urandom_range(3, 0);
      run_op(1'($urandom & 1), 1'($urandom & 1), 1'($urandom & 1), LANES'($urandom),
             rvec(), rvec(), rvec(), 1'($urandom & 1), lat);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_mem_stage.md
Name: vec_mem_stage

Overview:
- Memory stage of the vector pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes a 16-lane address vector and a 16-lane write-data vector and serialises them, one lane per transaction, onto a single-port 32-bit data-memory interface.
- Collects load data into a lane vector, then presents it with a one-cycle completion pulse for the MEM/WB register to capture.
- Holds the upstream pipeline through busy while the transfer runs.

Parameters:
- LANES, 16, number of vector lanes
- DW, 32, lane data width
- AW, 32, memory address width

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- in_valid  in  1  EX/MEM holds a valid instruction
- in_ready  out  1  stage can accept an instruction this cycle
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- v_s  in  1  1 = vector (all lanes), 0 = scalar (lane 0 only)
- addr  in  LANES*DW  per-lane byte address (lane i = bits [i*DW +: DW])
- wdata  in  LANES*DW  per-lane store data
- mem_req  out  1  memory request
- mem_we  out  1  request is a write
- mem_addr  out  AW  request address
- mem_wdata  out  DW  request write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DW  read data
- read_data  out  LANES*DW  collected load vector (to ReadDataM)
- out_valid  out  1  one-cycle completion pulse
- busy  out  1  stall request to the hazard unit

Behaviour:
- Reset (async, RST_N=0):
  - State goes to IDLE; lane counter = 0.
  - read_data = 0; out_valid = 0; mem_req = 0; busy = 0.
  - Operand latches are cleared.
- States are IDLE, REQ, WAIT, DONE.
- in_ready = (state == IDLE). busy = (state != IDLE). mem_req = (state == REQ), decoded directly from state.
- Accept:
  - An instruction is accepted on in_valid & in_ready.
  - On accept, latch addr, wdata, v_s and the op, clear read_data to 0, and set the lane counter to 0.
- Op decode on accept:
  - No memory op (mem_read = mem_write = 0): go straight to DONE.
  - Otherwise go to REQ.
  - mem_write has priority: mem_read & mem_write together is executed as a store.
- REQ:
  - Drive mem_addr = latched addr[lane] and mem_we = store.
  - For a store, also drive mem_wdata = latched wdata[lane].
  - Outputs are held stable until mem_gnt.
  - On mem_gnt for a store: advance the lane.
  - On mem_gnt for a load: go to WAIT.
- WAIT:
  - On mem_rvalid: read_data[lane] <= mem_rdata, then advance the lane.
  - mem_rvalid in any state other than WAIT is ignored.
  - Only one request is outstanding at a time.
- Advance lane:
  - Go to DONE if this was the last lane: lane == LANES-1, or lane 0 when v_s = 0.
  - Otherwise increment the lane counter and return to REQ.
- DONE:
  - out_valid = 1 for exactly one cycle, then go to IDLE.
  - There is no downstream backpressure.
- read_data is held after DONE until the next accept.
- Latency with mem_gnt tied high and mem_rvalid one cycle after grant (accept to out_valid):
  - Vector load: 2*LANES + 1 cycles = 33.
  - Vector store: LANES + 1 = 17.
  - Scalar load: 3; scalar store: 2.
  - Non-memory op: 1.
- in_valid while busy is not accepted; upstream holds its instruction.
- Address alignment is not checked; the address passes through unchanged.
- Reset asserted mid-transfer:
  - mem_req drops immediately.
  - No completion pulse is produced.
  - A late mem_rvalid after reset is ignored.

Optional Feature:
- Macro: VEC_MEM_LANE_MASK_EN.
- Defined:
  - Adds input lane_mask [LANES-1:0], latched on accept.
  - Lanes with mask bit 0 are skipped: no memory transaction, and read_data for that lane stays 0.
  - The skip takes 0 extra cycles; the counter jumps to the next enabled lane.
  - A mask of all zeros on a memory op goes directly to DONE.
  - For scalar ops only bit 0 is consulted.
- Undefined: the port does not exist and all lanes are active.

Test Plan:
- Vector load, addr[i] = 0x100 + 4i, memory returns 0xA000_0000 + i one cycle after immediate grant -> read_data[i] = 0xA000_0000 + i for all 16 lanes; out_valid high once, 33 cycles after accept; busy high throughout.
- Vector store, wdata[i] = i*3, mem_gnt delayed 2 cycles per request -> 16 writes in lane order with mem_addr/mem_wdata stable while mem_req & !mem_gnt; out_valid after 16*3 + 1 = 49 cycles.
- Scalar load (v_s = 0), addr[0] = 0x40, rdata 0xDEADBEEF -> exactly one mem_req; read_data[0] = 0xDEADBEEF, lanes 1..15 = 0; out_valid 3 cycles after accept.
- Non-memory op -> no mem_req; out_valid the next cycle; read_data = 0.
- RST_N pulsed low during lane 5 of a vector load, with stray mem_rvalid after release -> mem_req 0 immediately; state IDLE; read_data 0; no out_valid; next instruction accepted normally.
- With VEC_MEM_LANE_MASK_EN, vector load with mask 0x0005 -> only lanes 0 and 2 are requested; others read 0; out_valid 5 cycles after accept.
